// File: rtl/cnt_gate_ctrl.sv
// Gate controller and result sampler for the event counter: opens a timed count window, waits
// for the counter's input filter to settle, then captures the count and a wrap flag for readout.
// Optional feature: define CNT_GATE_AUTO_EN for continuous back-to-back measurements.
module cnt_gate_ctrl #(
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned GATE_WIDTH = 16,
  parameter int unsigned SETTLE_LEN = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [GATE_WIDTH-1:0] i_gate_len,
  input  logic [CNT_WIDTH-1:0]  i_cnt,
  output logic                  o_cnt_en,
  output logic                  o_cnt_rst,
  output logic [CNT_WIDTH-1:0]  o_result,
  output logic                  o_ovf,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int unsigned SetW = (SETTLE_LEN < 2) ? 1 : $clog2(SETTLE_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StHold
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [GATE_WIDTH-1:0] r_gate_len;
  logic [GATE_WIDTH-1:0] r_gate_tmr;
  logic [SetW-1:0]       r_set_tmr;
  logic [CNT_WIDTH-1:0]  r_cnt_prev;
  logic                  r_ovf_flag;
  logic                  r_cnt_en;
  logic                  r_cnt_rst;
  logic [CNT_WIDTH-1:0]  r_result;
  logic                  r_ovf;
  logic                  r_valid;
  logic                  r_busy;
  logic                  w_wrap;
  logic                  w_start_ok;

  assign w_wrap     = (i_cnt < r_cnt_prev);
  assign w_start_ok = i_start && (i_gate_len != '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_start_ok) w_state_nxt = StClear;
      StClear:  w_state_nxt = StGate;
      StGate:   if (r_gate_tmr == GATE_WIDTH'(1)) w_state_nxt = StSettle;
      StSettle: if (r_set_tmr == SetW'(1)) w_state_nxt = StHold;
      StHold: begin
        if (i_ready) begin
`ifdef CNT_GATE_AUTO_EN
          w_state_nxt = StClear;
`else
          w_state_nxt = StIdle;
`endif
        end
      end
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Output flags are decoded from the next state so every output is a plain register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_gate_len <= '0;
      r_gate_tmr <= '0;
      r_set_tmr  <= '0;
      r_cnt_prev <= '0;
      r_ovf_flag <= 1'b0;
      r_cnt_en   <= 1'b0;
      r_cnt_rst  <= 1'b0;
      r_result   <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_rst <= (w_state_nxt == StClear);
      r_cnt_en  <= (w_state_nxt == StGate);
      r_valid   <= (w_state_nxt == StHold);
      r_busy    <= (w_state_nxt != StIdle);
      unique case (r_state)
        StIdle: begin
          if (w_start_ok) r_gate_len <= i_gate_len;
        end
        StClear: begin
          r_gate_tmr <= r_gate_len;
          r_cnt_prev <= '0;
          r_ovf_flag <= 1'b0;
        end
        StGate: begin
          r_gate_tmr <= r_gate_tmr - GATE_WIDTH'(1);
          r_cnt_prev <= i_cnt;
          if (w_wrap) r_ovf_flag <= 1'b1;
          if (r_gate_tmr == GATE_WIDTH'(1)) r_set_tmr <= SetW'(SETTLE_LEN);
        end
        StSettle: begin
          r_set_tmr  <= r_set_tmr - SetW'(1);
          r_cnt_prev <= i_cnt;
          if (w_wrap) r_ovf_flag <= 1'b1;
          // A wrap seen on the capture cycle itself still counts for this measurement.
          if (r_set_tmr == SetW'(1)) begin
            r_result <= i_cnt;
            r_ovf    <= r_ovf_flag | w_wrap;
          end
        end
        StHold: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign o_cnt_en  = r_cnt_en;
  assign o_cnt_rst = r_cnt_rst;
  assign o_result  = r_result;
  assign o_ovf     = r_ovf;
  assign o_valid   = r_valid;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_cnt_gate_ctrl.sv
// Self-checking bench for cnt_gate_ctrl: table-driven windows, random windows against a
// timing/overflow model, and hand-written reset, zero-length and backpressure sequences.
module tb_cnt_gate_ctrl;
  localparam int CW = 8;
  localparam int GW = 16;
  localparam int SL = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic [GW-1:0] gate_len = '0;
  logic [CW-1:0] cnt = '0;
  logic          cnt_en, cnt_rst, ovf, valid, busy;
  logic [CW-1:0] result;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  cnt_gate_ctrl #(.CNT_WIDTH(CW), .GATE_WIDTH(GW), .SETTLE_LEN(SL)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_gate_len(gate_len),
    .i_cnt     (cnt),
    .o_cnt_en  (cnt_en),
    .o_cnt_rst (cnt_rst),
    .o_result  (result),
    .o_ovf     (ovf),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int c0;
    int c1;
    int rdy_dly;
    int exp_res;
    int exp_ovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One measurement. Cycle c is the cycle after edge c-1, edge 0 accepts start.
  // rnd=1 drives random counts; otherwise a stub counts c0 up to c1 during the gate.
  // exp_res/exp_ovf < 0 selects the model's own expectation.
  task automatic measure(input int len, input bit rnd, input int c0, input int c1,
                         input int rdy_dly, input int exp_res, input int exp_ovf);
    int last;
    int m_res;
    int m_ovf;
    int prev;
    logic [CW-1:0] v;
    logic [CW-1:0] vals[];
    last = len + 1 + SL;
    vals = new[last + 1];
    v = CW'(c0);
    for (int c = 2; c <= last; c++) begin
      if (rnd) vals[c] = CW'($urandom);
      else begin
        vals[c] = v;
        if (c < len + 1 && v != CW'(c1)) v = v + 1'b1;
      end
    end
    prev = 0;
    m_ovf = 0;
    for (int c = 2; c <= last; c++) begin
      if (int'(vals[c]) < prev) m_ovf = 1;
      prev = int'(vals[c]);
    end
    m_res = int'(vals[last]);
    if (exp_res >= 0) m_res = exp_res;
    if (exp_ovf >= 0) m_ovf = exp_ovf;

    start = 1'b1;
    gate_len = GW'(len);
    step();
    start = 1'b0;
    gate_len = GW'($urandom);
    for (int c = 1; c <= last; c++) begin
      cnt = (c >= 2) ? vals[c] : CW'($urandom);
      start = ($urandom_range(0, 3) == 0);
      sample();
      check("cnt_rst", cnt_rst, (c == 1));
      check("cnt_en", cnt_en, (c >= 2 && c <= len + 1));
      check("valid_early", valid, 0);
      check("busy", busy, 1);
      step();
    end
    cnt = CW'($urandom);
    ready = (rdy_dly == 0);
    sample();
    check("valid_rise", valid, 1);
    check("result", result, m_res);
    check("ovf", ovf, m_ovf);
    for (int k = 1; k <= rdy_dly; k++) begin
      step();
      ready = (k == rdy_dly);
      start = $urandom_range(0, 1);
      gate_len = GW'($urandom_range(1, 50));
      sample();
      check("hold_valid", valid, 1);
      check("hold_result", result, m_res);
      check("hold_ovf", ovf, m_ovf);
      check("hold_cnt_rst", cnt_rst, 0);
    end
    step();
    ready = 1'b0;
    start = 1'b0;
    sample();
    check("valid_drop", valid, 0);
    check("kept_result", result, m_res);
    check("kept_ovf", ovf, m_ovf);
`ifdef CNT_GATE_AUTO_EN
    check("auto_cnt_rst", cnt_rst, 1);
    check("auto_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`else
    check("idle_busy", busy, 0);
    check("idle_cnt_rst", cnt_rst, 0);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{len: 10, c0: 0,   c1: 7,   rdy_dly: 0,  exp_res: 7,   exp_ovf: 0};
    vecs[1] = '{len: 20, c0: 250, c1: 4,   rdy_dly: 0,  exp_res: 4,   exp_ovf: 1};
    vecs[2] = '{len: 12, c0: 3,   c1: 9,   rdy_dly: 15, exp_res: 9,   exp_ovf: 0};
    vecs[3] = '{len: 1,  c0: 5,   c1: 5,   rdy_dly: 2,  exp_res: 5,   exp_ovf: 0};
    vecs[4] = '{len: 15, c0: 255, c1: 3,   rdy_dly: 1,  exp_res: 3,   exp_ovf: 1};
    vecs[5] = '{len: 30, c0: 200, c1: 210, rdy_dly: 3,  exp_res: 210, exp_ovf: 0};

    // Reset held for two cycles.
    rst_n = 1'b0;
    step();
    step();
    sample();
    check("rst_cnt_en", cnt_en, 0);
    check("rst_cnt_rst", cnt_rst, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Zero-length start requests are ignored.
    start = 1'b1;
    gate_len = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      sample();
      check("zero_len_busy", busy, 0);
      check("zero_len_cnt_rst", cnt_rst, 0);
    end
    start = 1'b0;
    step();

    foreach (vecs[i])
      measure(vecs[i].len, 1'b0, vecs[i].c0, vecs[i].c1, vecs[i].rdy_dly,
              vecs[i].exp_res, vecs[i].exp_ovf);

    for (int i = 0; i < 8; i++)
      measure($urandom_range(1, 40), 1'b1, 0, 0, $urandom_range(0, 5), -1, -1);

    // Reset during cycle 5 of a 100-cycle gate aborts the measurement.
    start = 1'b1;
    gate_len = GW'(100);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sample();
    check("abort_cnt_en", cnt_en, 0);
    check("abort_busy", busy, 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 150; i++) begin
        step();
        sample();
        if (valid) seen++;
      end
      check("abort_no_valid", seen, 0);
    end

`ifdef CNT_GATE_AUTO_EN
    begin
      int t0;
      int t1;
      t0 = -1;
      t1 = -1;
      ready = 1'b1;
      start = 1'b1;
      gate_len = GW'(5);
      step();
      start = 1'b0;
      for (int i = 0; i < 200 && t0 < 0; i++) begin
        sample();
        if (valid) t0 = cyc;
        else step();
      end
      check("auto_first_valid_seen", (t0 >= 0), 1);
      step();
      sample();
      check("auto_loop_cnt_rst", cnt_rst, 1);
      for (int i = 0; i < 200 && t1 < 0; i++) begin
        sample();
        if (valid) t1 = cyc;
        else step();
      end
      check("auto_valid_spacing", t1 - t0, 5 + SL + 2);
      ready = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
    end
`endif

    // Longest gate the timer supports.
    measure(65535, 1'b0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
